// File: rtl/lcd_ctrl_4bit.sv
// HD44780-style 4-bit LCD sequencer: runs the power-on init itself, then writes one command/data
// byte per req/busy handshake as two nibble strobes followed by the controller's execution wait.
module lcd_ctrl_4bit #(
    parameter int CNT_W       = 20,
    parameter int T_PWR       = 750000,
    parameter int T_INIT_WAIT = 205000,
    parameter int T_SETUP     = 2,
    parameter int T_EPULSE    = 12,
    parameter int T_HOLD      = 1,
    parameter int T_CMD_WAIT  = 2000,
    parameter int T_CLR_WAIT  = 82000
) (
    input  logic       clk,
    input  logic       nClear,
    input  logic       req,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       ready,
    output logic [3:0] dataout,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_PWR       = CNT_W'(T_PWR);
    localparam logic [CNT_W-1:0] C_INIT_WAIT = CNT_W'(T_INIT_WAIT);
    localparam logic [CNT_W-1:0] C_SETUP     = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] C_EPULSE    = CNT_W'(T_EPULSE);
    localparam logic [CNT_W-1:0] C_HOLD      = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] C_CMD_WAIT  = CNT_W'(T_CMD_WAIT);
    localparam logic [CNT_W-1:0] C_CLR_WAIT  = CNT_W'(T_CLR_WAIT);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [2:0]       step_reg;   // init item in progress: 0..3 raw nibbles, 4..7 init bytes
    logic             init_reg;
    logic             raw_reg;    // stand-alone init nibble, followed by the long init wait
    logic             low_reg;    // low nibble of byte_reg is being sent
    logic [7:0]       byte_reg;

    logic             phase_done;
    logic             clr_byte;
    logic [7:0]       next_init_byte;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    init_byte = 8'h28;
            2'd1:    init_byte = 8'h06;
            2'd2:    init_byte = 8'h0C;
            default: init_byte = 8'h01;
        endcase
    endfunction

    assign phase_done     = (cnt_reg == C_ONE);
    // Clear/home commands need the long execution wait; LCD_RS holds the latched rs of the byte.
    assign clr_byte       = !LCD_RS && (byte_reg <= 8'h03);
    assign next_init_byte = init_byte(2'(step_reg - 3'd3));

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            state_reg <= ST_PWR_WAIT;
            cnt_reg   <= C_PWR;
            step_reg  <= 3'd0;
            init_reg  <= 1'b1;
            raw_reg   <= 1'b1;
            low_reg   <= 1'b0;
            byte_reg  <= 8'h00;
            busy      <= 1'b1;
            ready     <= 1'b0;
            dataout   <= 4'h0;
            LCD_E     <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_RW    <= 1'b0;
        end else begin
            LCD_RW <= 1'b0;
            if (state_reg != ST_IDLE && !phase_done) begin
                cnt_reg <= cnt_reg - C_ONE;
            end
            case (state_reg)
                ST_PWR_WAIT: begin
                    if (phase_done) begin
                        state_reg <= ST_SETUP;
                        cnt_reg   <= C_SETUP;
                        dataout   <= 4'h3;
                        LCD_RS    <= 1'b0;
                        raw_reg   <= 1'b1;
                        low_reg   <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (phase_done) begin
                        state_reg <= ST_PULSE;
                        cnt_reg   <= C_EPULSE;
                        LCD_E     <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (phase_done) begin
                        state_reg <= ST_HOLD;
                        cnt_reg   <= C_HOLD;
                        LCD_E     <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (phase_done) begin
                        if (raw_reg || low_reg) begin
                            state_reg <= ST_WAIT;
                            if (raw_reg) begin
                                cnt_reg <= C_INIT_WAIT;
                            end else if (clr_byte) begin
                                cnt_reg <= C_CLR_WAIT;
                            end else begin
                                cnt_reg <= C_CMD_WAIT;
                            end
                        end else begin
                            state_reg <= ST_SETUP;
                            cnt_reg   <= C_SETUP;
                            low_reg   <= 1'b1;
                            dataout   <= byte_reg[3:0];
                        end
                    end
                end
                ST_WAIT: begin
                    if (phase_done) begin
                        if (!init_reg || step_reg == 3'd7) begin
                            state_reg <= ST_IDLE;
                            init_reg  <= 1'b0;
                            busy      <= 1'b0;
                            ready     <= 1'b1;
                        end else begin
                            // Advance to the next init item: three 3s, a 2, then the init bytes.
                            state_reg <= ST_SETUP;
                            cnt_reg   <= C_SETUP;
                            step_reg  <= step_reg + 3'd1;
                            LCD_RS    <= 1'b0;
                            low_reg   <= 1'b0;
                            if (step_reg < 3'd3) begin
                                raw_reg <= 1'b1;
                                dataout <= (step_reg == 3'd2) ? 4'h2 : 4'h3;
                            end else begin
                                raw_reg  <= 1'b0;
                                byte_reg <= next_init_byte;
                                dataout  <= next_init_byte[7:4];
                            end
                        end
                    end
                end
                ST_IDLE: begin
                    if (req && !busy) begin
                        state_reg <= ST_SETUP;
                        cnt_reg   <= C_SETUP;
                        busy      <= 1'b1;
                        byte_reg  <= data_in;
                        LCD_RS    <= rs_in;
                        dataout   <= data_in[7:4];
                        raw_reg   <= 1'b0;
                        low_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_PWR_WAIT;
                    cnt_reg   <= C_PWR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_4bit.sv
// Bench for lcd_ctrl_4bit: expected nibble strobes and busy lengths are queued when stimulus is
// issued; a negedge monitor pops and compares them as the LCD pins show each strobe and busy window.
`timescale 1ns/1ps
module tb_lcd_ctrl_4bit;

    localparam int T_PWR       = 10;
    localparam int T_INIT_WAIT = 5;
    localparam int T_SETUP     = 2;
    localparam int T_EPULSE    = 3;
    localparam int T_HOLD      = 1;
    localparam int T_CMD_WAIT  = 4;
    localparam int T_CLR_WAIT  = 8;
    localparam int NIB_T       = T_SETUP + T_EPULSE + T_HOLD;

    logic       clk;
    logic       nClear;
    logic       req;
    logic       rs_in;
    logic [7:0] data_in;
    logic       busy;
    logic       ready;
    logic [3:0] dataout;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;

    lcd_ctrl_4bit #(
        .CNT_W      (20),
        .T_PWR      (T_PWR),
        .T_INIT_WAIT(T_INIT_WAIT),
        .T_SETUP    (T_SETUP),
        .T_EPULSE   (T_EPULSE),
        .T_HOLD     (T_HOLD),
        .T_CMD_WAIT (T_CMD_WAIT),
        .T_CLR_WAIT (T_CLR_WAIT)
    ) dut (
        .clk    (clk),
        .nClear (nClear),
        .req    (req),
        .rs_in  (rs_in),
        .data_in(data_in),
        .busy   (busy),
        .ready  (ready),
        .dataout(dataout),
        .LCD_E  (LCD_E),
        .LCD_RS (LCD_RS),
        .LCD_RW (LCD_RW)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    int         init_cycles;
    logic [4:0] exp_nib[$];
    int         exp_busy[$];
    logic [7:0] init_seq[4];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: busy time of one byte, from the wait rule for clear/home commands.
    function automatic int byte_time(input logic rs, input logic [7:0] d);
        return 2 * NIB_T + ((!rs && d <= 8'h03) ? T_CLR_WAIT : T_CMD_WAIT);
    endfunction

    task automatic expect_byte(input logic rs, input logic [7:0] d);
        exp_nib.push_back({rs, d[7:4]});
        exp_nib.push_back({rs, d[3:0]});
        exp_busy.push_back(byte_time(rs, d));
    endtask

    task automatic push_init();
        logic [7:0] b;
        exp_nib.push_back(5'h03);
        exp_nib.push_back(5'h03);
        exp_nib.push_back(5'h03);
        exp_nib.push_back(5'h02);
        for (int i = 0; i < 4; i++) begin
            b = init_seq[i];
            exp_nib.push_back({1'b0, b[7:4]});
            exp_nib.push_back({1'b0, b[3:0]});
        end
    endtask

    // Monitor: one compare per E strobe and per post-init busy window.
    logic       e_prev, b_prev, b_on, nib_ok;
    int         e_len, b_len, stable;
    logic [4:0] cap, last_bus, mbus, exp_n;
    int         exp_b;

    always @(negedge clk) begin
        if (!mon_en || !nClear) begin
            e_prev   = 1'b0;
            b_prev   = 1'b1;
            b_on     = 1'b0;
            stable   = 0;
            last_bus = 5'h00;
        end else begin
            mbus = {LCD_RS, dataout};
            if (LCD_E && !e_prev) begin
                nib_ok = (stable >= T_SETUP) && (mbus == last_bus);
                cap    = mbus;
                e_len  = 1;
            end else if (LCD_E && e_prev) begin
                e_len++;
                if (mbus != cap) nib_ok = 1'b0;
            end else if (!LCD_E && e_prev) begin
                if (exp_nib.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL nibble_extra got=%02h exp=none", cap);
                end else begin
                    exp_n = exp_nib.pop_front();
                    chk("nibble", 32'(cap), 32'(exp_n));
                    chk("e_width", e_len, T_EPULSE);
                    chk("setup_stable", 32'(nib_ok), 1);
                    chk("rw", 32'(LCD_RW), 0);
                    $display("nibble rs=%0d d=%h e_len=%0d", cap[4], cap[3:0], e_len);
                end
            end
            if (busy && !b_prev && ready) begin
                b_on  = 1'b1;
                b_len = 1;
            end else if (busy && b_on) begin
                b_len++;
            end else if (!busy && b_on) begin
                b_on = 1'b0;
                if (exp_busy.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_extra got=%0d exp=none", b_len);
                end else begin
                    exp_b = exp_busy.pop_front();
                    chk("busy_len", b_len, exp_b);
                end
            end
            if (mbus == last_bus) stable++;
            else stable = 1;
            last_bus = mbus;
            e_prev   = LCD_E;
            b_prev   = busy;
        end
    end

    task automatic wait_not_busy();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0) chk("busy_timeout", 32'(busy), 0);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] d);
        wait_not_busy();
        rs_in   = rs;
        data_in = d;
        req     = 1'b1;
        expect_byte(rs, d);
        $display("xfer rs=%0d data=%02h", rs, d);
        @(posedge clk); #1;
        req     = 1'b0;
        rs_in   = 1'($urandom);
        data_in = 8'($urandom);
        chk("accept", 32'(busy), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy !== 1'b0 || exp_nib.size() != 0 || exp_busy.size() != 0) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy !== 1'b0 || exp_nib.size() != 0 || exp_busy.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%b nib_left=%0d busy_left=%0d exp=0",
                     busy, exp_nib.size(), exp_busy.size());
        end
    endtask

    task automatic release_and_count();
        int n = 0;
        nClear = 1'b1;
        while (ready !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("init_cycles", n, init_cycles);
        chk("busy_after_init", 32'(busy), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dataout"}, 32'(dataout), 0);
        chk({tag, "_e"}, 32'(LCD_E), 0);
        chk({tag, "_rs"}, 32'(LCD_RS), 0);
        chk({tag, "_rw"}, 32'(LCD_RW), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_ready"}, 32'(ready), 0);
    endtask

    logic       rs_t;
    logic [7:0] d_t;
    bit         found;
    int         nw;

    initial begin
        clk     = 1'b0;
        nClear  = 1'b1;
        req     = 1'b0;
        rs_in   = 1'b0;
        data_in = 8'h00;
        init_seq[0] = 8'h28;
        init_seq[1] = 8'h06;
        init_seq[2] = 8'h0C;
        init_seq[3] = 8'h01;
        init_cycles = T_PWR + 4 * (NIB_T + T_INIT_WAIT);
        for (int i = 0; i < 4; i++) init_cycles += byte_time(1'b0, init_seq[i]);

        // Asynchronous reset, checked before any clock edge follows.
        #22 nClear = 1'b0;
        #1 check_reset_outputs("reset");
        push_init();
        mon_en = 1'b1;
        #15 release_and_count();

        // Single data byte, then command bytes on both sides of the clear-wait boundary.
        send_byte(1'b1, 8'h41);
        wait_idle();
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'h80);
        send_byte(1'b0, 8'h03);
        send_byte(1'b0, 8'h04);
        send_byte(1'b1, 8'h02);
        send_byte(1'b0, 8'h00);
        wait_idle();

        // req held high: junk on the inputs mid-transfer, next byte taken on the first idle edge.
        wait_not_busy();
        rs_t    = 1'($urandom);
        d_t     = 8'($urandom);
        rs_in   = rs_t;
        data_in = d_t;
        req     = 1'b1;
        expect_byte(rs_t, d_t);
        $display("xfer rs=%0d data=%02h held", rs_t, d_t);
        @(posedge clk); #1;
        chk("b2b_accept", 32'(busy), 1);
        for (int k = 1; k < 6; k++) begin
            repeat (5) begin
                rs_in   = 1'($urandom);
                data_in = 8'($urandom);
                @(posedge clk); #1;
            end
            rs_t    = 1'($urandom);
            d_t     = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            rs_in   = rs_t;
            data_in = d_t;
            expect_byte(rs_t, d_t);
            $display("xfer rs=%0d data=%02h held", rs_t, d_t);
            nw = 0;
            while (busy !== 1'b0 && nw < 100) begin
                @(posedge clk); #1;
                nw++;
            end
            chk("b2b_idle", 32'(busy), 0);
            @(posedge clk); #1;
            chk("b2b_gap", 32'(busy), 1);
        end
        req = 1'b0;
        wait_idle();

        // Randomised bytes with random idle gaps, biased toward the clear/home range.
        for (int i = 0; i < 30; i++) begin
            rs_t = 1'($urandom);
            d_t  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
            send_byte(rs_t, d_t);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle();

        // Reset in the middle of an E pulse, then a full re-init.
        send_byte(1'b1, 8'h5A);
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(posedge clk); #2;
            if (LCD_E === 1'b1) found = 1'b1;
        end
        chk("pulse_found", 32'(found), 1);
        #1 nClear = 1'b0;
        #1 check_reset_outputs("midpulse");
        exp_nib.delete();
        exp_busy.delete();
        push_init();
        @(posedge clk);
        @(posedge clk);
        #4 release_and_count();

        send_byte(1'b1, 8'h7E);
        send_byte(1'b0, 8'h02);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
